// File: rtl/ddr_ram_pkg.sv
// -----------------------------------------------------------------------------
// ddr_ram_pkg
//   Shared definitions for the DDR controller datapath RAMs.
//
//   Contents:
//     RDW_READ_FIRST / RDW_WRITE_FIRST : encodings of the same-address
//                                        read-during-write policy.
//     BYTE_W                           : lane width covered by one byte enable.
//     byte_merge()                     : one-lane merge of old and new data
//                                        under a byte enable. Callers replicate
//                                        it across their own BW = WIDTH/8 lanes,
//                                        so the function itself carries no
//                                        width parameter.
// -----------------------------------------------------------------------------
package ddr_ram_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int BYTE_W = 8;

  // Select the new lane when its enable is set, otherwise keep the old lane.
  function automatic logic [BYTE_W-1:0] byte_merge(
    input logic [BYTE_W-1:0] old_byte,
    input logic [BYTE_W-1:0] new_byte,
    input logic              be
  );
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ddr_ram_rd_pipe.sv
// -----------------------------------------------------------------------------
// ddr_ram_rd_pipe
//   Read-return delay line of RD_LAT register stages (1 or 2) carrying a
//   valid bit and a data word. The data registers load only when the valid
//   bit entering them is set, so the output word holds its last value while
//   no read is in flight. Valid bits are cleared by the asynchronous reset,
//   which discards any reads still travelling through the line.
//
//   There is no handshake: a result leaves the line exactly RD_LAT cycles
//   after it enters, with no stall and no backpressure.
//
//   Ports:
//     clk       : clock, all logic on posedge
//     rst_n     : asynchronous active-low reset
//     in_valid  : a read result enters this cycle
//     in_data   : that read result (array word, merged word, or zero)
//     out_valid : one-cycle strobe marking a result on out_data
//     out_data  : registered read data, held between results
// -----------------------------------------------------------------------------
module ddr_ram_rd_pipe #(
  parameter int WIDTH  = 64,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;

  // Stage 1 captures the read result on the issue edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
  end else begin : g_lat1
    assign out_valid = s1_valid;
    assign out_data  = s1_data;
  end

endmodule

// File: rtl/ddr_sdp_ram_be.sv
// -----------------------------------------------------------------------------
// ddr_sdp_ram_be
//   Single-clock simple-dual-port RAM with per-byte write enables, a
//   selectable read latency of 1 or 2 cycles, a fixed read-during-write
//   policy and a read-valid strobe. Used as write-data / read-return buffer
//   storage in the DDR4 controller datapath, where the byte enables carry
//   the DM mask.
//
//   Parameters:
//     DEPTH    : number of words (>= 2, any value)
//     WIDTH    : word width in bits (multiple of 8)
//     RD_LAT   : read latency in cycles, 1 or 2
//     RDW_MODE : same-address read-during-write result,
//                RDW_READ_FIRST (old word) or RDW_WRITE_FIRST (merged word)
//
//   Ports:
//     clk    : clock, all logic on posedge
//     rst_n  : asynchronous active-low reset (read pipeline only; the array
//              contents survive reset)
//     wen    : write enable
//     waddr  : write address; addresses >= DEPTH are ignored
//     wdata  : write data
//     wbe    : byte enables, bit i covers wdata[8i+7:8i]
//     ren    : read enable
//     raddr  : read address; addresses >= DEPTH read as all-zero
//     rdata  : read data, held between results
//     rvalid : one-cycle strobe marking a read result on rdata
//
//   Interface timing: a read sampled with ren=1 on a clock edge presents its
//   result on rdata with rvalid=1 RD_LAT edges later (the sampling edge
//   counts as the first). Reads are accepted every cycle; there is no
//   ready/backpressure signal in either direction.
// -----------------------------------------------------------------------------
module ddr_sdp_ram_be
  import ddr_ram_pkg::*;
#(
  parameter  int DEPTH    = 64,
  parameter  int WIDTH    = 64,
  parameter  int RD_LAT   = 1,
  parameter  int RDW_MODE = 0,
  localparam int AW       = $clog2(DEPTH),
  localparam int BW       = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [BW-1:0]    wbe,
  input  logic             ren,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("ddr_sdp_ram_be: RD_LAT must be 1 or 2");
  end
  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_bad_width
    $error("ddr_sdp_ram_be: WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("ddr_sdp_ram_be: DEPTH must be at least 2");
  end
  if (RDW_MODE != RDW_READ_FIRST && RDW_MODE != RDW_WRITE_FIRST) begin : g_bad_rdw
    $error("ddr_sdp_ram_be: RDW_MODE must be 0 or 1");
  end

  // One extra bit so the range compare is exact even when DEPTH == 2**AW.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_do;
  logic             collision;
  logic [WIDTH-1:0] mem_wr_old;
  logic [WIDTH-1:0] mem_rd_word;
  logic [WIDTH-1:0] wr_word;
  logic [WIDTH-1:0] rd_word;

  assign wr_in_range = ({1'b0, waddr} < DEPTH_W);
  assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
  assign wr_do       = wen && wr_in_range;

  // Out-of-range addresses never index the array; they see a zero word.
  assign mem_wr_old  = wr_in_range ? mem[waddr] : '0;
  assign mem_rd_word = rd_in_range ? mem[raddr] : '0;

  // The write is a read-modify-write of the full word: disabled lanes are
  // written back unchanged, so wbe == 0 leaves the word as it was.
  for (genvar b = 0; b < BW; b++) begin : g_merge
    assign wr_word[b*BYTE_W +: BYTE_W] = byte_merge(mem_wr_old[b*BYTE_W +: BYTE_W],
                                                    wdata[b*BYTE_W +: BYTE_W],
                                                    wbe[b]);
  end

  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem[waddr] <= wr_word;
    end
  end

  // On a same-address collision waddr == raddr, so the word being written
  // (wr_word) is exactly the merged word a write-first read must return.
  assign collision = wen && ren && rd_in_range && (waddr == raddr);

  always_comb begin
    rd_word = mem_rd_word;
    if (RDW_MODE == RDW_WRITE_FIRST && collision) begin
      rd_word = wr_word;
    end
  end

  ddr_ram_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (ren),
    .in_data   (rd_word),
    .out_valid (rvalid),
    .out_data  (rdata)
  );

endmodule
